// File: rtl/adc_scan_pkg.sv
// Shared constants and state encoding for the ADC scan sequencer.
package adc_scan_pkg;

  localparam int NumChannels  = 8;
  localparam int ChWidth      = 3;
  localparam int AdcDataWidth = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Bus between the scan sequencer (master) and the ADC128S022 SPI driver (slave).
interface adc_scan_sequencer_if;
  import adc_scan_pkg::*;

  logic                    adc_start;
  logic                    adc_stop;
  logic                    adc_done;
  logic [AdcDataWidth-1:0] adc_data;
  logic [ChWidth-1:0]      adc_addr;

  modport master (
    output adc_start,
    output adc_stop,
    output adc_addr,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    input  adc_stop,
    input  adc_addr,
    output adc_done,
    output adc_data
  );

endinterface

// File: rtl/adc_scan_next_ch.sv
// Channel-mask search: next enabled channel above cur_ch (wrapping to the
// lowest), plus the lowest and highest enabled channels of the mask.
// With only cur_ch enabled, next_ch wraps back onto cur_ch.
module adc_scan_next_ch
  import adc_scan_pkg::*;
(
  input  logic [NumChannels-1:0] mask,
  input  logic [ChWidth-1:0]     cur_ch,
  output logic [ChWidth-1:0]     next_ch,
  output logic [ChWidth-1:0]     lowest_ch,
  output logic [ChWidth-1:0]     highest_ch
);

  logic [ChWidth-1:0] idx_s;
  logic               found_s;

  // Walk upward from cur_ch+1 around to cur_ch itself; first set bit wins.
  always_comb begin
    next_ch = cur_ch;
    found_s = 1'b0;
    idx_s   = cur_ch;
    for (int i = 1; i <= NumChannels; i++) begin
      idx_s   = cur_ch + ChWidth'(i);
      next_ch = (!found_s && mask[idx_s]) ? idx_s : next_ch;
      found_s = found_s | mask[idx_s];
    end
  end

  // Lowest and highest set bits; both read 0 for an empty mask.
  always_comb begin
    lowest_ch  = '0;
    highest_ch = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      lowest_ch = mask[i] ? ChWidth'(i) : lowest_ch;
    end
    for (int i = 0; i < NumChannels; i++) begin
      highest_ch = mask[i] ? ChWidth'(i) : highest_ch;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans the enabled ADC128S022 channels in ascending order through the SPI
// driver, averaging 2^AvgLog2 conversions per channel. The device returns
// the conversion for the address sent one frame earlier, so each frame's
// address is parked in pend_ch and its data is credited on the next frame.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int AvgLog2 = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_start,
  input  logic                    scan_stop,
  input  logic                    continuous,
  input  logic [NumChannels-1:0]  ch_enable,
  adc_scan_sequencer_if.master    adc,
  output logic                    result_valid,
  output logic [ChWidth-1:0]      result_ch,
  output logic [AdcDataWidth-1:0] result_data,
  output logic                    scan_done,
  output logic                    busy
);

  localparam int NumReps = 1 << AvgLog2;
  localparam int RepW    = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam int AccW    = AdcDataWidth + AvgLog2;
  localparam logic [RepW-1:0] RepLast = RepW'(NumReps - 1);

  scan_state_e            state_r;
  logic [NumChannels-1:0] mask_r;
  logic                   cont_r;
  logic [ChWidth-1:0]     issue_ch_r;
  logic [RepW-1:0]        rep_cnt_r;
  logic [RepW-1:0]        samp_cnt_r;
  logic [AccW-1:0]        acc_r;
  logic [ChWidth-1:0]     pend_ch_r;
  logic                   pend_valid_r;

  logic [NumChannels-1:0] search_mask_s;
  logic [ChWidth-1:0]     next_ch_s;
  logic [ChWidth-1:0]     lowest_ch_s;
  logic [ChWidth-1:0]     highest_ch_s;
  logic [AccW-1:0]        acc_sum_s;
  logic                   samp_last_s;
  logic                   rep_last_s;
  logic                   last_issue_s;

  // In IDLE the search looks at the incoming mask (to find the first channel);
  // otherwise it works on the latched mask.
  assign search_mask_s = (state_r == IDLE) ? ch_enable : mask_r;

  adc_scan_next_ch u_next_ch (
    .mask       (search_mask_s),
    .cur_ch     (issue_ch_r),
    .next_ch    (next_ch_s),
    .lowest_ch  (lowest_ch_s),
    .highest_ch (highest_ch_s)
  );

  assign acc_sum_s   = acc_r + AccW'(adc.adc_data);
  assign samp_last_s = (samp_cnt_r == RepLast);
  assign rep_last_s  = (rep_cnt_r == RepLast);
  // The address now on the bus is the final real one of a single-shot pass.
  assign last_issue_s = !cont_r && rep_last_s && (issue_ch_r == highest_ch_s);

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mask_r        <= '0;
      cont_r        <= 1'b0;
      issue_ch_r    <= '0;
      rep_cnt_r     <= '0;
      samp_cnt_r    <= '0;
      acc_r         <= '0;
      pend_ch_r     <= '0;
      pend_valid_r  <= 1'b0;
      adc.adc_start <= 1'b0;
      adc.adc_stop  <= 1'b0;
      adc.adc_addr  <= '0;
      result_valid  <= 1'b0;
      result_ch     <= '0;
      result_data   <= '0;
      scan_done     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      adc.adc_start <= 1'b0;
      adc.adc_stop  <= 1'b0;
      result_valid  <= 1'b0;
      scan_done     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (scan_start && (ch_enable != '0)) begin
            mask_r        <= ch_enable;
            cont_r        <= continuous;
            issue_ch_r    <= lowest_ch_s;
            rep_cnt_r     <= '0;
            samp_cnt_r    <= '0;
            acc_r         <= '0;
            pend_valid_r  <= 1'b0;
            adc.adc_addr  <= lowest_ch_s;
            adc.adc_start <= 1'b1;
            busy          <= 1'b1;
            state_r       <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (scan_stop) begin
            // Abort wins over a coincident frame; partial average is dropped.
            acc_r        <= '0;
            samp_cnt_r   <= '0;
            pend_valid_r <= 1'b0;
            state_r      <= HALT;
          end else if (adc.adc_done) begin
            // Credit this frame's data to the address sent one frame earlier.
            if (pend_valid_r) begin
              if (samp_last_s) begin
                result_valid <= 1'b1;
                result_ch    <= pend_ch_r;
                result_data  <= AdcDataWidth'(acc_sum_s >> AvgLog2);
                scan_done    <= (pend_ch_r == highest_ch_s);
                acc_r        <= '0;
                samp_cnt_r   <= '0;
              end else begin
                acc_r        <= acc_sum_s;
                samp_cnt_r   <= samp_cnt_r + RepW'(1);
              end
            end
            pend_ch_r    <= adc.adc_addr;
            pend_valid_r <= 1'b1;
            // Issue the next address; after the last real one only filler
            // frames remain and the address is held.
            if (state_r == DRAIN) begin
              state_r <= HALT;
            end else if (last_issue_s) begin
              state_r <= DRAIN;
            end else if (rep_last_s) begin
              rep_cnt_r    <= '0;
              issue_ch_r   <= next_ch_s;
              adc.adc_addr <= next_ch_s;
            end else begin
              rep_cnt_r    <= rep_cnt_r + RepW'(1);
            end
          end
        end
        HALT: begin
          adc.adc_stop <= 1'b1;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer. Two instances (AvgLog2=0 and
// AvgLog2=2) share stimulus and are reset before every scenario. Expected
// results are queued with the frame number that should produce them.
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_start;
  logic        scan_stop;
  logic        continuous;
  logic [7:0]  ch_enable;
  logic        adc_done;
  logic [11:0] adc_data;

  logic        rv0, sd0, busy0, rv2, sd2, busy2;
  logic [2:0]  rch0, rch2;
  logic [11:0] rd0, rd2;

  adc_scan_sequencer_if if0();
  adc_scan_sequencer_if if2();

  assign if0.adc_done = adc_done;
  assign if0.adc_data = adc_data;
  assign if2.adc_done = adc_done;
  assign if2.adc_data = adc_data;

  adc_scan_sequencer #(.AvgLog2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start), .scan_stop(scan_stop),
    .continuous(continuous), .ch_enable(ch_enable), .adc(if0),
    .result_valid(rv0), .result_ch(rch0), .result_data(rd0),
    .scan_done(sd0), .busy(busy0)
  );

  adc_scan_sequencer #(.AvgLog2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start), .scan_stop(scan_stop),
    .continuous(continuous), .ch_enable(ch_enable), .adc(if2),
    .result_valid(rv2), .result_ch(rch2), .result_data(rd2),
    .scan_done(sd2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [2:0]  ch;
    logic [11:0] data;
    logic        done;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         frame_no = 0;
  logic [2:0] prev_sent = 3'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int fr, input logic [2:0] ch, input logic [11:0] d, input logic dn);
    exp_t e;
    e.frame = fr; e.ch = ch; e.data = d; e.done = dn;
    sb_q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, obs, exp);
    end
  endtask

  // Asynchronous reset in mid-cycle; all outputs must clear before any edge.
  task automatic apply_reset();
    logic [34:0] o0, o2;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    o0 = {rv0, rch0, rd0, sd0, busy0, if0.adc_start, if0.adc_stop, if0.adc_addr};
    o2 = {rv2, rch2, rd2, sd2, busy2, if2.adc_start, if2.adc_stop, if2.adc_addr};
    checks++;
    if (o0 !== 35'd0) begin failures++; $display("FAIL reset_outputs_dut0 got=%h expected=0", o0); end
    checks++;
    if (o2 !== 35'd0) begin failures++; $display("FAIL reset_outputs_dut2 got=%h expected=0", o2); end
    scan_start = 1'b0; scan_stop = 1'b0; continuous = 1'b0;
    ch_enable = 8'd0; adc_done = 1'b0; adc_data = 12'd0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_scan(input bit use2, input logic [7:0] mask, input logic cont, input logic [2:0] exp_addr);
    ch_enable = mask; continuous = cont; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check_bit("start_pulse", use2 ? if2.adc_start : if0.adc_start, 1'b1);
    check_bit("start_busy", use2 ? busy2 : busy0, 1'b1);
    checks++;
    if ((use2 ? if2.adc_addr : if0.adc_addr) !== exp_addr) begin
      failures++;
      $display("FAIL start_addr got=%0d expected=%0d", (use2 ? if2.adc_addr : if0.adc_addr), exp_addr);
    end
    frame_no = 0;
    prev_sent = 3'd0;
    tick();
    check_bit("start_one_cycle", use2 ? if2.adc_start : if0.adc_start, 1'b0);
  endtask

  // One driver frame: data is {address sent last frame, 9'h0AB} for dut0,
  // or data_arg for dut2. Compares against the scoreboard head.
  task automatic frame(input bit use2, input logic [11:0] data_arg, input logic stop_too);
    logic [2:0]  cur_sent;
    logic        ov, osd;
    logic [2:0]  och;
    logic [11:0] od;
    exp_t        e;
    cur_sent = use2 ? if2.adc_addr : if0.adc_addr;
    frame_no++;
    adc_data = use2 ? data_arg : {prev_sent, 9'h0AB};
    prev_sent = cur_sent;
    adc_done = 1'b1;
    scan_stop = stop_too;
    tick();
    adc_done = 1'b0;
    scan_stop = 1'b0;
    ov  = use2 ? rv2 : rv0;
    och = use2 ? rch2 : rch0;
    od  = use2 ? rd2 : rd0;
    osd = use2 ? sd2 : sd0;
    checks++;
    if (sb_q.size() != 0 && sb_q[0].frame == frame_no) begin
      e = sb_q.pop_front();
      if ({ov, och, od, osd} !== {1'b1, e.ch, e.data, e.done}) begin
        failures++;
        $display("FAIL result_frame%0d got v=%b ch=%0d data=%h done=%b expected v=1 ch=%0d data=%h done=%b",
                 frame_no, ov, och, od, osd, e.ch, e.data, e.done);
      end
    end else begin
      if ({ov, osd} !== 2'b00) begin
        failures++;
        $display("FAIL no_result_frame%0d got v=%b done=%b expected v=0 done=0", frame_no, ov, osd);
      end
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_results got=%0d expected=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_bit("idle_busy", busy0, 1'b0);
    frame(1'b0, 12'd0, 1'b0);   // adc_done in IDLE must be ignored
    check_bit("idle_no_start", if0.adc_start, 1'b0);
  endtask

  task automatic test_single_shot();
    apply_reset();
    start_scan(1'b0, 8'b0010_0101, 1'b0, 3'd0);
    push(2, 3'd0, 12'h0AB, 1'b0);
    push(3, 3'd2, 12'h4AB, 1'b0);
    push(4, 3'd5, 12'hAAB, 1'b1);
    frame(1'b0, 12'd0, 1'b0); tick();
    frame(1'b0, 12'd0, 1'b0);
    checks++;
    if (if0.adc_addr !== 3'd5) begin failures++; $display("FAIL ss_addr got=%0d expected=5", if0.adc_addr); end
    tick();
    frame(1'b0, 12'd0, 1'b0);
    checks++;
    if (if0.adc_addr !== 3'd5) begin failures++; $display("FAIL ss_addr_hold got=%0d expected=5", if0.adc_addr); end
    tick();
    frame(1'b0, 12'd0, 1'b0);
    check_bit("ss_stop_not_yet", if0.adc_stop, 1'b0);
    tick();
    check_bit("ss_stop_pulse", if0.adc_stop, 1'b1);
    tick();
    check_bit("ss_stop_end", if0.adc_stop, 1'b0);
    check_bit("ss_busy_low", busy0, 1'b0);
    check_sb_empty("single_shot");
  endtask

  task automatic test_average();
    apply_reset();
    start_scan(1'b1, 8'b0000_1000, 1'b0, 3'd3);
    push(5, 3'd3, 12'd101, 1'b1);
    frame(1'b1, 12'hFFF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      frame(1'b1, 12'd100 + 12'(k), 1'b0);
    end
    tick();
    check_bit("avg_stop_pulse", if2.adc_stop, 1'b1);
    tick();
    check_bit("avg_busy_low", busy2, 1'b0);
    check_sb_empty("average");
  endtask

  task automatic test_continuous();
    apply_reset();
    start_scan(1'b0, 8'b1000_0001, 1'b1, 3'd0);
    push(2, 3'd0, 12'h0AB, 1'b0);
    push(3, 3'd7, 12'hEAB, 1'b1);
    push(4, 3'd0, 12'h0AB, 1'b0);
    frame(1'b0, 12'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      frame(1'b0, 12'd0, 1'b0);
    end
    tick();
    check_bit("cont_still_busy", busy0, 1'b1);
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
    check_bit("cont_stop_not_yet", if0.adc_stop, 1'b0);
    tick();
    check_bit("cont_stop_pulse", if0.adc_stop, 1'b1);
    tick();
    check_bit("cont_busy_low", busy0, 1'b0);
    frame(1'b0, 12'd0, 1'b0);   // no result may follow the stop
    check_sb_empty("continuous");
  endtask

  task automatic test_ignored_starts();
    apply_reset();
    ch_enable = 8'd0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check_bit("empty_mask_no_start", if0.adc_start, 1'b0);
    check_bit("empty_mask_no_busy", busy0, 1'b0);
    start_scan(1'b0, 8'b0000_0010, 1'b0, 3'd1);
    ch_enable = 8'b1000_0000; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check_bit("busy_start_ignored", if0.adc_start, 1'b0);
    push(2, 3'd1, 12'h2AB, 1'b1);
    frame(1'b0, 12'd0, 1'b0); tick();
    frame(1'b0, 12'd0, 1'b0); tick();
    check_bit("ign_stop_pulse", if0.adc_stop, 1'b1);
    check_sb_empty("ignored_starts");
  endtask

  task automatic test_stop_coincident();
    apply_reset();
    start_scan(1'b0, 8'b0000_0011, 1'b0, 3'd0);
    frame(1'b0, 12'd0, 1'b0); tick();
    frame(1'b0, 12'd0, 1'b1);   // stop and done together: no result
    check_bit("coin_stop_not_yet", if0.adc_stop, 1'b0);
    tick();
    check_bit("coin_stop_pulse", if0.adc_stop, 1'b1);
    tick();
    check_bit("coin_busy_low", busy0, 1'b0);
    check_sb_empty("stop_coincident");
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    start_scan(1'b0, 8'b0000_0101, 1'b0, 3'd0);
    push(2, 3'd0, 12'h0AB, 1'b0);
    frame(1'b0, 12'd0, 1'b0); tick();
    frame(1'b0, 12'd0, 1'b0);
    check_bit("mid_busy_before_reset", busy0, 1'b1);
    check_sb_empty("mid_run_pre");
    apply_reset();
    start_scan(1'b0, 8'b0000_0100, 1'b0, 3'd2);
    push(2, 3'd2, 12'h4AB, 1'b1);
    frame(1'b0, 12'd0, 1'b0); tick();
    frame(1'b0, 12'd0, 1'b0); tick();
    check_bit("mid_restart_stop", if0.adc_stop, 1'b1);
    check_sb_empty("mid_run_post");
  endtask

  initial begin
    rst_n = 1'b0; scan_start = 1'b0; scan_stop = 1'b0; continuous = 1'b0;
    ch_enable = 8'd0; adc_done = 1'b0; adc_data = 12'd0;
    test_reset();
    test_single_shot();
    test_average();
    test_continuous();
    test_ignored_starts();
    test_stop_coincident();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
